noc_vc_router: RTL and testbench

- Single-flit, credit-flow-controlled 2D-mesh router with NUM_VCS virtual channels per port.
- Provides per-input-VC buffering, dimension-ordered XY routing, per-output round-robin allocation across all (input, VC) requesters, per-output-VC credit counters and a registered output stage.
- Next-generation mesh router: generalised to multiple VCs and configurable widths and depths, with link-down flit dropping and error/statistics reporting.

---
 rtl/noc_vc_router.sv | 205 ++++++++++++++++++++
 tb/tb_noc_vc_router.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_router.sv
// Five-port XY mesh router with per-input-VC FIFOs, per-output round-robin
// allocation over all (port, VC) heads, credit tracking and registered outputs.
module noc_vc_router #(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VCS      = 2,
  parameter int VC_W         = 1,
  parameter int PACKET_WIDTH = 128,
  parameter int VC_DEPTH     = 4,
  parameter int COORD_W      = 4,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COORD_W-1:0]                cur_x,
  input  logic [COORD_W-1:0]                cur_y,
  input  logic [NUM_PORTS-1:0]              link_up,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [NUM_PORTS*VC_W-1:0]         in_vc,
  input  logic [NUM_PORTS*PACKET_WIDTH-1:0] in_flit,
  output logic [NUM_PORTS*NUM_VCS-1:0]      in_credit,
  output logic [NUM_PORTS-1:0]              out_valid,
  output logic [NUM_PORTS*VC_W-1:0]         out_vc,
  output logic [NUM_PORTS*PACKET_WIDTH-1:0] out_flit,
  input  logic [NUM_PORTS*NUM_VCS-1:0]      out_credit,
  output logic [CNT_W-1:0]                  drop_count,
  output logic                              overflow_err
);

  localparam int NR     = NUM_PORTS * NUM_VCS;
  localparam int PTR_W  = $clog2(VC_DEPTH);
  localparam int CRED_W = $clog2(VC_DEPTH + 1);
  localparam int RR_W   = $clog2(NR);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  logic [PACKET_WIDTH-1:0] mem    [NUM_PORTS][NUM_VCS][VC_DEPTH];
  logic [PTR_W-1:0]        wr_ptr [NUM_PORTS][NUM_VCS];
  logic [PTR_W-1:0]        rd_ptr [NUM_PORTS][NUM_VCS];
  logic [PTR_W:0]          count  [NUM_PORTS][NUM_VCS];
  logic [CRED_W-1:0]       credit [NUM_PORTS][NUM_VCS];
  logic [RR_W-1:0]         rr_ptr [NUM_PORTS];

  logic [PACKET_WIDTH-1:0] head   [NUM_PORTS][NUM_VCS];
  logic [2:0]              route  [NUM_PORTS][NUM_VCS];
  logic                    drop   [NUM_PORTS][NUM_VCS];
  logic                    pop    [NUM_PORTS][NUM_VCS];
  logic                    wr_en  [NUM_PORTS][NUM_VCS];
  logic [NR-1:0]           req    [NUM_PORTS];
  logic [NUM_PORTS-1:0]    gnt_valid;
  logic [RR_W-1:0]         gnt_idx  [NUM_PORTS];
  logic [NUM_VCS-1:0]      dec      [NUM_PORTS];
  logic [PACKET_WIDTH-1:0] win_flit [NUM_PORTS];
  logic [VC_W-1:0]         win_vc   [NUM_PORTS];
  logic [CNT_W-1:0]        drop_num;
  logic                    ovf_any;
  logic [CNT_W:0]          drop_sum;

  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy,
                                          input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
    if (dx > x)      return P_EAST;
    else if (dx < x) return P_WEST;
    else if (dy > y) return P_NORTH;
    else if (dy < y) return P_SOUTH;
    else             return P_LOCAL;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        head[p][v]  = mem[p][v][rd_ptr[p][v]];
        route[p][v] = xy_route(head[p][v][PACKET_WIDTH-1 -: COORD_W],
                               head[p][v][PACKET_WIDTH-COORD_W-1 -: COORD_W],
                               cur_x, cur_y);
      end
    end
  end

  // Heads bound for a dead link are flushed; live heads request their one output.
  always_comb begin
    drop_num = '0;
    for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        drop[p][v] = (count[p][v] != '0) && !link_up[route[p][v]];
        drop_num   = drop_num + CNT_W'(drop[p][v]);
        for (int o = 0; o < NUM_PORTS; o++) begin
          if ((count[p][v] != '0) && (route[p][v] == 3'(o)) && link_up[o] &&
              (credit[o][v] != '0))
            req[o][p*NUM_VCS+v] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_valid[o] = 1'b0;
      gnt_idx[o]   = '0;
      for (int k = 0; k < NR; k++) begin
        if (!gnt_valid[o] && req[o][(int'(rr_ptr[o]) + k) % NR]) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = RR_W'((int'(rr_ptr[o]) + k) % NR);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      for (int v = 0; v < NUM_VCS; v++)
        pop[p][v] = drop[p][v];
    for (int o = 0; o < NUM_PORTS; o++) begin
      dec[o]      = '0;
      win_flit[o] = '0;
      win_vc[o]   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (gnt_valid[o] && (int'(gnt_idx[o]) == p*NUM_VCS + v)) begin
            pop[p][v]   = 1'b1;
            dec[o][v]   = 1'b1;
            win_flit[o] = head[p][v];
            win_vc[o]   = VC_W'(v);
          end
        end
      end
    end
  end

  // A write that matches no VC with free space (bad VC id or full FIFO) is lost.
  always_comb begin
    ovf_any = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic written;
      written = 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_en[p][v] = in_valid[p] && (in_vc[p*VC_W +: VC_W] == VC_W'(v)) &&
                      (count[p][v] != (PTR_W+1)'(VC_DEPTH));
        written = written | wr_en[p][v];
      end
      ovf_any = ovf_any | (in_valid[p] && !written);
    end
    drop_sum = {1'b0, drop_count} + {1'b0, drop_num};
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      for (int v = 0; v < NUM_VCS; v++)
        if (wr_en[p][v])
          mem[p][v][wr_ptr[p][v]] <= in_flit[p*PACKET_WIDTH +: PACKET_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rr_ptr[p] <= '0;
        for (int v = 0; v < NUM_VCS; v++) begin
          wr_ptr[p][v] <= '0;
          rd_ptr[p][v] <= '0;
          count[p][v]  <= '0;
          credit[p][v] <= CRED_W'(VC_DEPTH);
        end
      end
      out_valid    <= '0;
      out_vc       <= '0;
      out_flit     <= '0;
      in_credit    <= '0;
      drop_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (wr_en[p][v]) wr_ptr[p][v] <= wr_ptr[p][v] + 1'b1;
          if (pop[p][v])   rd_ptr[p][v] <= rd_ptr[p][v] + 1'b1;
          if (wr_en[p][v] && !pop[p][v])      count[p][v] <= count[p][v] + 1'b1;
          else if (!wr_en[p][v] && pop[p][v]) count[p][v] <= count[p][v] - 1'b1;
          in_credit[p*NUM_VCS+v] <= pop[p][v];
        end
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          if (dec[o][v] && !out_credit[o*NUM_VCS+v])
            credit[o][v] <= credit[o][v] - 1'b1;
          else if (!dec[o][v] && out_credit[o*NUM_VCS+v] &&
                   (credit[o][v] != CRED_W'(VC_DEPTH)))
            credit[o][v] <= credit[o][v] + 1'b1;
        end
        out_valid[o] <= gnt_valid[o];
        if (gnt_valid[o]) begin
          rr_ptr[o] <= RR_W'((int'(gnt_idx[o]) + 1) % NR);
          out_flit[o*PACKET_WIDTH +: PACKET_WIDTH] <= win_flit[o];
          out_vc[o*VC_W +: VC_W] <= win_vc[o];
        end
      end
      drop_count   <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      overflow_err <= overflow_err | ovf_any;
    end
  end

endmodule

// File: tb/tb_noc_vc_router.sv
// Directed bench for noc_vc_router: routing, latency, round-robin, credits,
// link-down drops, overflow and mid-run reset, with hand-computed expectations.
module tb_noc_vc_router;
  localparam int NP = 5, NV = 2, VW = 1, PW = 128, CW = 4, DEP = 4, CNTW = 16;
  localparam int L = 0, NO = 1, E = 2, S = 3, W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CW-1:0]     cur_x, cur_y;
  logic [NP-1:0]     link_up;
  logic [NP-1:0]     in_valid;
  logic [NP*VW-1:0]  in_vc;
  logic [NP*PW-1:0]  in_flit;
  logic [NP*NV-1:0]  in_credit;
  logic [NP-1:0]     out_valid;
  logic [NP*VW-1:0]  out_vc;
  logic [NP*PW-1:0]  out_flit;
  logic [NP*NV-1:0]  out_credit;
  logic [CNTW-1:0]   drop_count;
  logic              overflow_err;

  int checks = 0;
  int fails  = 0;

  noc_vc_router #(.NUM_PORTS(NP), .NUM_VCS(NV), .VC_W(VW), .PACKET_WIDTH(PW),
                  .VC_DEPTH(DEP), .COORD_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .link_up(link_up),
    .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit), .in_credit(in_credit),
    .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit),
    .out_credit(out_credit), .drop_count(drop_count), .overflow_err(overflow_err));

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input int dx, input int dy, input int tag);
    logic [PW-1:0] f;
    f = '0;
    f[PW-1 -: CW]    = dx[CW-1:0];
    f[PW-CW-1 -: CW] = dy[CW-1:0];
    f[15:0]          = tag[15:0];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid   = '0;
    in_vc      = '0;
    in_flit    = '0;
    out_credit = '0;
  endtask

  task automatic set_in(input int p, input int vc, input logic [PW-1:0] f);
    in_valid[p]          = 1'b1;
    in_vc[p*VW +: VW]    = vc[VW-1:0];
    in_flit[p*PW +: PW]  = f;
  endtask

  task automatic do_reset();
    clear_inputs();
    link_up = '1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    link_up = '1;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== '0) begin fails++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_vc !== '0) begin fails++; $display("[TB] FAIL reset_out_vc got %b want 0", out_vc); end
    checks++; if (out_flit !== '0) begin fails++; $display("[TB] FAIL reset_out_flit got %h want 0", out_flit); end
    checks++; if (in_credit !== '0) begin fails++; $display("[TB] FAIL reset_in_credit got %b want 0", in_credit); end
    checks++; if (drop_count !== '0) begin fails++; $display("[TB] FAIL reset_drop_count got %0d want 0", drop_count); end
    checks++; if (overflow_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow got %b want 0", overflow_err); end
    rst = 1'b0;
  endtask

  task automatic test_basic_latency();
    logic [PW-1:0] f;
    do_reset();
    f = mk(3, 1, 16'h0101);
    set_in(L, 0, f);
    tick();
    clear_inputs();
    checks++; if (out_valid !== 5'b00000) begin fails++; $display("[TB] FAIL basic_early got %b want 00000", out_valid); end
    tick();
    checks++; if (out_valid !== 5'b00100) begin fails++; $display("[TB] FAIL basic_valid got %b want 00100", out_valid); end
    checks++; if (out_flit[E*PW +: PW] !== f) begin fails++; $display("[TB] FAIL basic_flit got %h want %h", out_flit[E*PW +: PW], f); end
    checks++; if (out_vc[E*VW +: VW] !== 1'b0) begin fails++; $display("[TB] FAIL basic_vc got %b want 0", out_vc[E*VW +: VW]); end
    checks++; if (in_credit !== 10'b0000000001) begin fails++; $display("[TB] FAIL basic_in_credit got %b want 0000000001", in_credit); end
    tick();
    checks++; if (out_valid !== 5'b00000) begin fails++; $display("[TB] FAIL basic_after got %b want 00000", out_valid); end
    checks++; if (in_credit !== '0) begin fails++; $display("[TB] FAIL basic_credit_once got %b want 0", in_credit); end
  endtask

  task automatic test_routes();
    int dxs [4] = '{1, 1, 0, 1};
    int dys [4] = '{1, 0, 1, 2};
    int exps[4] = '{L, S, W, NO};
    logic [PW-1:0] f;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      f = mk(dxs[i], dys[i], 16'h0200 + i);
      set_in(E, 1, f);
      tick();
      clear_inputs();
      tick();
      checks++; if (out_valid !== 5'(1 << exps[i])) begin fails++; $display("[TB] FAIL route_%0d_valid got %b want %b", i, out_valid, 5'(1 << exps[i])); end
      checks++; if (out_flit[exps[i]*PW +: PW] !== f) begin fails++; $display("[TB] FAIL route_%0d_flit got %h want %h", i, out_flit[exps[i]*PW +: PW], f); end
      checks++; if (out_vc[exps[i]*VW +: VW] !== 1'b1) begin fails++; $display("[TB] FAIL route_%0d_vc got %b want 1", i, out_vc[exps[i]*VW +: VW]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int srcp[3] = '{NO, S, W};
    int srcv[3] = '{0, 1, 0};
    do_reset();
    for (int s = 0; s < 3; s++) set_in(srcp[s], srcv[s], mk(3, 1, 16'h0300 + s*16));
    for (int c = 1; c <= 11; c++) begin
      int k;
      tick();
      clear_inputs();
      if (c < 3)
        for (int s = 0; s < 3; s++) set_in(srcp[s], srcv[s], mk(3, 1, 16'h0300 + s*16 + c));
      if (c >= 2 && c <= 10) begin
        k = c - 2;
        checks++; if (out_valid[E] !== 1'b1) begin fails++; $display("[TB] FAIL rr_valid_%0d got %b want 1", k, out_valid[E]); end
        checks++; if (out_flit[E*PW +: PW] !== mk(3, 1, 16'h0300 + (k%3)*16 + k/3)) begin
          fails++; $display("[TB] FAIL rr_flit_%0d got %h want %h", k, out_flit[E*PW +: PW], mk(3, 1, 16'h0300 + (k%3)*16 + k/3));
        end
        if (out_valid[E] === 1'b1) out_credit[E*NV + int'(out_vc[E*VW +: VW])] = 1'b1;
      end
      if (c == 11) begin
        checks++; if (out_valid[E] !== 1'b0) begin fails++; $display("[TB] FAIL rr_drain got %b want 0", out_valid[E]); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_credit_stall();
    int n0, n1, extra;
    do_reset();
    out_credit[E*NV] = 1'b1;
    tick();
    tick();
    clear_inputs();
    n0 = 0;
    for (int c = 0; c < 14; c++) begin
      clear_inputs();
      if (c < 6) set_in(L, 0, mk(3, 1, 16'h0400 + c));
      tick();
      if (out_valid[E] === 1'b1) begin
        checks++; if (out_flit[E*PW +: PW] !== mk(3, 1, 16'h0400 + n0)) begin
          fails++; $display("[TB] FAIL credit_flit_%0d got %h want %h", n0, out_flit[E*PW +: PW], mk(3, 1, 16'h0400 + n0));
        end
        n0++;
      end
    end
    clear_inputs();
    checks++; if (n0 !== 4) begin fails++; $display("[TB] FAIL credit_vc0_count got %0d want 4", n0); end
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      if (c < 2) set_in(L, 1, mk(3, 1, 16'h0500 + c));
      tick();
      if (out_valid[E] === 1'b1) begin
        if (out_vc[E*VW +: VW] === 1'b1) n1++;
        else n0++;
      end
    end
    clear_inputs();
    checks++; if (n1 !== 2) begin fails++; $display("[TB] FAIL credit_vc1_flow got %0d want 2", n1); end
    checks++; if (n0 !== 0) begin fails++; $display("[TB] FAIL credit_vc0_stalled got %0d want 0", n0); end
    out_credit[E*NV] = 1'b1;
    tick();
    clear_inputs();
    checks++; if (out_valid[E] !== 1'b0) begin fails++; $display("[TB] FAIL credit_return_early got %b want 0", out_valid[E]); end
    tick();
    checks++; if (out_valid[E] !== 1'b1) begin fails++; $display("[TB] FAIL credit_return_valid got %b want 1", out_valid[E]); end
    checks++; if (out_vc[E*VW +: VW] !== 1'b0) begin fails++; $display("[TB] FAIL credit_return_vc got %b want 0", out_vc[E*VW +: VW]); end
    checks++; if (out_flit[E*PW +: PW] !== mk(3, 1, 16'h0404)) begin
      fails++; $display("[TB] FAIL credit_return_flit got %h want %h", out_flit[E*PW +: PW], mk(3, 1, 16'h0404));
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid[E] === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("[TB] FAIL credit_single_only got %0d want 0", extra); end
  endtask

  task automatic test_drop_overflow();
    int ve;
    do_reset();
    link_up = 5'b11011;
    set_in(L, 0, mk(3, 1, 16'h0600));
    set_in(NO, 1, mk(3, 1, 16'h0601));
    set_in(S, 0, mk(3, 1, 16'h0602));
    tick();
    clear_inputs();
    checks++; if (drop_count !== 16'd0) begin fails++; $display("[TB] FAIL drop_before got %0d want 0", drop_count); end
    ve = int'(out_valid[E]);
    tick();
    ve += int'(out_valid[E]);
    checks++; if (drop_count !== 16'd3) begin fails++; $display("[TB] FAIL drop_count3 got %0d want 3", drop_count); end
    checks++; if (in_credit !== 10'b0001001001) begin fails++; $display("[TB] FAIL drop_in_credit got %b want 0001001001", in_credit); end
    tick();
    ve += int'(out_valid[E]);
    checks++; if (in_credit !== '0) begin fails++; $display("[TB] FAIL drop_credit_once got %b want 0", in_credit); end
    set_in(W, 1, mk(3, 1, 16'h0603));
    tick();
    clear_inputs();
    ve += int'(out_valid[E]);
    tick();
    ve += int'(out_valid[E]);
    checks++; if (drop_count !== 16'd4) begin fails++; $display("[TB] FAIL drop_count4 got %0d want 4", drop_count); end
    checks++; if (ve !== 0) begin fails++; $display("[TB] FAIL drop_no_east got %0d want 0", ve); end
    link_up = '1;
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); set_in(L, 1, mk(0, 1, 16'h0610 + i)); tick();
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); set_in(L, 1, mk(0, 1, 16'h0620 + i)); tick();
    end
    clear_inputs();
    tick();
    checks++; if (overflow_err !== 1'b0) begin fails++; $display("[TB] FAIL ovf_at_full got %b want 0", overflow_err); end
    set_in(L, 1, mk(0, 1, 16'h0630));
    tick();
    clear_inputs();
    checks++; if (overflow_err !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set got %b want 1", overflow_err); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (overflow_err !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    set_in(L, 0, mk(3, 1, 16'h0700));
    tick();
    clear_inputs();
    set_in(L, 0, mk(3, 1, 16'h0701));
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== '0) begin fails++; $display("[TB] FAIL mid_out_valid got %b want 0", out_valid); end
    checks++; if (out_flit !== '0) begin fails++; $display("[TB] FAIL mid_out_flit got %h want 0", out_flit); end
    checks++; if (in_credit !== '0) begin fails++; $display("[TB] FAIL mid_in_credit got %b want 0", in_credit); end
    n = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid !== '0 || in_credit !== '0) n++;
    end
    checks++; if (n !== 0) begin fails++; $display("[TB] FAIL mid_discard got %0d active cycles want 0", n); end
    n = 0;
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      if (c < 5) set_in(L, 0, mk(3, 1, 16'h0710 + c));
      tick();
      if (out_valid[E] === 1'b1) n++;
    end
    clear_inputs();
    checks++; if (n !== 4) begin fails++; $display("[TB] FAIL mid_credit_restore got %0d want 4", n); end
  endtask

  initial begin
    rst   = 1'b1;
    cur_x = 4'd1;
    cur_y = 4'd1;
    link_up = '1;
    clear_inputs();
    test_reset();
    test_basic_latency();
    test_routes();
    test_round_robin();
    test_credit_stall();
    test_drop_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
